// File: rtl/common_rrarb4_ctrl.sv
// common_rrarb4_ctrl
//   Four-way round-robin arbiter and sequencer for a shared single-beat resource
//   port. Registers a one-hot grant, offers it to the resource through a
//   valid/ready handshake, pulses ack to the winner on accept and rotates
//   priority to the requester after the winner.
//
// Ports
//   clk      in   clock, all state on rising edge
//   resetn   in   asynchronous active-low reset
//   req      in   [3:0] per-requester request level, held until matching ack
//   lock     in   hold the grant on the current winner (COMMON_RRARB4_LOCK_EN only)
//   o_ready  in   shared resource accepts the current beat
//   o_valid  out  a grant is active and a beat is offered
//   gnt      out  [3:0] registered one-hot grant, zero when idle
//   gidx     out  [1:0] binary index of the granted requester
//   ack      out  [3:0] one-cycle pulse to the winner on accept
//   busy     out  equals o_valid
//
// Configuration
//   COMMON_RRARB4_LOCK_EN  when defined, an accept with lock=1 and the winner
//                          still requesting keeps the same grant (bursts).
//                          When undefined, lock is ignored.

module common_rrarb4_ctrl (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] req,
  input  logic       lock,
  input  logic       o_ready,
  output logic       o_valid,
  output logic [3:0] gnt,
  output logic [1:0] gidx,
  output logic [3:0] ack,
  output logic       busy
);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e     state_q;
  logic [1:0] ptr_q;
  logic [1:0] base;
  logic [1:0] win;
  logic [1:0] cand;
  logic       found;
  logic       any_req;
  logic       accept;
  logic       hold;

  assign any_req = |req;
  assign o_valid = (state_q == StGrant);
  assign busy    = o_valid;
  assign accept  = o_valid & o_ready;
  assign ack     = gnt & {4{accept}};

`ifdef COMMON_RRARB4_LOCK_EN
  assign hold = lock & req[gidx];
`else
  logic unused_lock;
  assign unused_lock = lock;
  assign hold        = 1'b0;
`endif

  // In GRANT the search is only consumed on accept, where the pointer is about
  // to become gidx+1; using that directly gives zero-bubble re-arbitration.
  always_comb begin
    base  = (state_q == StGrant) ? gidx + 2'd1 : ptr_q;
    win   = base;
    cand  = base;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = base + i[1:0];
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      gnt     <= 4'b0000;
      gidx    <= 2'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q <= StGrant;
            gidx    <= win;
            gnt     <= 4'b0001 << win;
          end
        end
        StGrant: begin
          if (o_ready && !hold) begin
            ptr_q <= gidx + 2'd1;
            if (any_req) begin
              gidx <= win;
              gnt  <= 4'b0001 << win;
            end else begin
              state_q <= StIdle;
              gidx    <= 2'd0;
              gnt     <= 4'b0000;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_common_rrarb4_ctrl.sv
module tb_common_rrarb4_ctrl;

  logic       clk;
  logic       resetn;
  logic [3:0] req;
  logic       lock;
  logic       o_ready;
  logic       o_valid;
  logic [3:0] gnt;
  logic [1:0] gidx;
  logic [3:0] ack;
  logic       busy;

  int n_checks;
  int n_fail;

  common_rrarb4_ctrl dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .lock    (lock),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .gnt     (gnt),
    .gidx    (gidx),
    .ack     (ack),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn  = 1'b0;
    req     = 4'b0000;
    lock    = 1'b0;
    o_ready = 1'b0;
    #1;
    n_checks++;
    if ({o_valid, busy, gnt, gidx, ack} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_vals got v=%b b=%b g=%b i=%0d a=%b want all zero",
               o_valid, busy, gnt, gidx, ack);
    end
    tick();
    tick();
    resetn = 1'b1;
    tick();
    n_checks++;
    if (o_valid !== 1'b0 || gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_noreq got v=%b g=%b want v=0 g=0000", o_valid, gnt);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_oh;
    req     = 4'b1111;
    o_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_oh = 4'b0001 << (i % 4);
      n_checks++;
      if (gidx !== 2'(i % 4) || gnt !== exp_oh || o_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rot_grant step %0d got i=%0d g=%b v=%b want i=%0d g=%b v=1",
                 i, gidx, gnt, o_valid, i % 4, exp_oh);
      end
      n_checks++;
      if (ack !== exp_oh) begin
        n_fail++;
        $display("FAIL rot_ack step %0d got %b want %b", i, ack, exp_oh);
      end
    end
  endtask

  // Entered in GRANT gidx=0 with o_ready=1.
  task automatic test_wrap();
    req = 4'b1000;
    tick();
    n_checks++;
    if (gidx !== 2'd3 || ack !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap_at3 got i=%0d a=%b want i=3 a=1000", gidx, ack);
    end
    req = 4'b1001;
    tick();
    n_checks++;
    if (gidx !== 2'd0 || gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_to0 got i=%0d g=%b want i=0 g=0001", gidx, gnt);
    end
  endtask

  task automatic test_backpressure();
    req = 4'b0100;
    tick();
    n_checks++;
    if (gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_setup got g=%b want 0100", gnt);
    end
    o_ready = 1'b0;
    req     = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (gnt !== 4'b0100 || gidx !== 2'd2 || ack !== 4'b0000 || o_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold cyc %0d got g=%b i=%0d a=%b v=%b want g=0100 i=2 a=0000 v=1",
                 i, gnt, gidx, ack, o_valid);
      end
    end
    o_ready = 1'b1;
    #1;
    n_checks++;
    if (ack !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_ack got %b want 0100", ack);
    end
    tick();
    n_checks++;
    if (gidx !== 2'd0 || gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL bp_next got i=%0d g=%b want i=0 g=0001", gidx, gnt);
    end
  endtask

  // Entered in GRANT gidx=0, o_ready=1.
  task automatic test_accept_empty();
    req = 4'b0000;
    #1;
    n_checks++;
    if (ack !== 4'b0001) begin
      n_fail++;
      $display("FAIL empty_ack got %b want 0001", ack);
    end
    tick();
    n_checks++;
    if (o_valid !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000 || ack !== 4'b0000) begin
      n_fail++;
      $display("FAIL empty_idle got v=%b b=%b g=%b a=%b want 0 0 0000 0000",
               o_valid, busy, gnt, ack);
    end
    tick();
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_stay got v=%b want 0", o_valid);
    end
    req = 4'b0001;
    tick();
    n_checks++;
    if (o_valid !== 1'b1 || gidx !== 2'd0 || gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL empty_regrant got v=%b i=%0d g=%b want v=1 i=0 g=0001",
               o_valid, gidx, gnt);
    end
  endtask

  // Entered in GRANT gidx=0 with ptr=1. Moves ptr to 2 before resetting so a
  // pointer that survives reset would pick requester 3 instead of 1.
  task automatic test_reset_mid();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0001;
    tick();
    n_checks++;
    if (gidx !== 2'd0 || o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_setup got i=%0d v=%b want i=0 v=1", gidx, o_valid);
    end
    o_ready = 1'b1;
    resetn  = 1'b0;
    #1;
    n_checks++;
    if ({o_valid, busy, gnt, gidx, ack} !== 12'h000) begin
      n_fail++;
      $display("FAIL rstmid_clear got v=%b b=%b g=%b i=%0d a=%b want all zero",
               o_valid, busy, gnt, gidx, ack);
    end
    tick();
    resetn  = 1'b1;
    o_ready = 1'b0;
    req     = 4'b1010;
    tick();
    n_checks++;
    if (gidx !== 2'd1 || gnt !== 4'b0010 || o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_grant got i=%0d g=%b v=%b want i=1 g=0010 v=1",
               gidx, gnt, o_valid);
    end
  endtask

  // Entered in GRANT gidx=1, ptr=0, o_ready=0.
  task automatic test_lock();
    req     = 4'b0011;
    o_ready = 1'b1;
    lock    = 1'b0;
    tick();
    n_checks++;
    if (gidx !== 2'd0) begin
      n_fail++;
      $display("FAIL lock_setup got i=%0d want 0", gidx);
    end
    lock = 1'b1;
`ifdef COMMON_RRARB4_LOCK_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (gidx !== 2'd0 || ack !== 4'b0001) begin
        n_fail++;
        $display("FAIL lock_hold beat %0d got i=%0d a=%b want i=0 a=0001", i, gidx, ack);
      end
    end
    lock = 1'b0;
    tick();
    n_checks++;
    if (gidx !== 2'd1) begin
      n_fail++;
      $display("FAIL lock_release got i=%0d want 1", gidx);
    end
`else
    tick();
    n_checks++;
    if (gidx !== 2'd1) begin
      n_fail++;
      $display("FAIL lock_ignored got i=%0d want 1", gidx);
    end
    tick();
    n_checks++;
    if (gidx !== 2'd0) begin
      n_fail++;
      $display("FAIL lock_ignored2 got i=%0d want 0", gidx);
    end
`endif
    lock    = 1'b0;
    o_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_rotation();
    test_wrap();
    test_backpressure();
    test_accept_empty();
    test_reset_mid();
    test_lock();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
